// File: rtl/clock_pkg.sv
// Shared types and BCD digit limits for the clock core.
package clock_pkg;

   typedef enum logic [1:0] {StRun, StSetTime, StSetAlarm} state_t;
   typedef enum logic [1:0] {FldHour, FldMin, FldSec} field_t;

   localparam logic [3:0] LsbMax       = 4'd9;
   localparam logic [3:0] MinSecMsbMax = 4'd5;
   localparam logic [3:0] HourMsbMax   = 4'd2;
   localparam logic [3:0] HourLsbMax   = 4'd3;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD field counter, modulus 60 (min/sec) or 24 (hour).
module bcd2_counter
   import clock_pkg::*;
#(
   parameter int unsigned Modulus = 60
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc,
   output logic [3:0] msb,
   output logic [3:0] lsb,
   output logic [3:0] nxt_msb,
   output logic [3:0] nxt_lsb,
   output logic       carry
);

   localparam logic [3:0] MaxMsb = (Modulus == 24) ? HourMsbMax : MinSecMsbMax;
   localparam logic [3:0] MaxLsb = (Modulus == 24) ? HourLsbMax : LsbMax;

   logic [3:0] msb_q, lsb_q;

   // carry marks the terminal value: an increment here wraps to 00
   assign carry = (msb_q == MaxMsb) && (lsb_q == MaxLsb);

   always_comb begin
      nxt_msb = msb_q;
      nxt_lsb = lsb_q + 4'd1;
      if (carry) begin
         nxt_msb = 4'd0;
         nxt_lsb = 4'd0;
      end else if (lsb_q == LsbMax) begin
         nxt_msb = msb_q + 4'd1;
         nxt_lsb = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         msb_q <= 4'd0;
         lsb_q <= 4'd0;
      end else if (inc) begin
         msb_q <= nxt_msb;
         lsb_q <= nxt_lsb;
      end
   end

   assign msb = msb_q;
   assign lsb = lsb_q;

endmodule

// File: rtl/clock_core.sv
// Alarm clock core: prescaler, run/set-time/set-alarm FSM, BCD time and alarm registers.
// Define ALARM_AUTOOFF_EN to clear a ringing alarm automatically after 60 seconds.
module clock_core
   import clock_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       mode_btn,
   input  logic       sel_btn,
   input  logic       inc_btn,
   output logic       settime,
   output logic [3:0] insecMSB,
   output logic [3:0] insecLSB,
   output logic [3:0] inminMSB,
   output logic [3:0] inminLSB,
   output logic [3:0] inhourMSB,
   output logic [3:0] inhourLSB,
   output logic [3:0] alarmsecMSB,
   output logic [3:0] alarmsecLSB,
   output logic [3:0] alarmminMSB,
   output logic [3:0] alarmminLSB,
   output logic [3:0] alarmhourMSB,
   output logic [3:0] alarmhourLSB,
   output logic       alarm_ring
);

   localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);

   state_t          state_q;
   field_t          field_q;
   logic [PW-1:0]   presc_q;
   logic            settime_q, ring_q;
`ifdef ALARM_AUTOOFF_EN
   logic [5:0]      ring_cnt_q;
`endif

   logic sec_tick, any_btn, mode_p, sel_p, inc_p, t_man, a_man, alarm_hit;
   logic t_sec_inc, t_min_inc, t_hour_inc, a_sec_inc, a_min_inc, a_hour_inc;
   logic t_sec_c, t_min_c, t_hour_c, a_sec_c, a_min_c, a_hour_c;
   logic [3:0] t_sec_nm, t_sec_nl, t_min_nm, t_min_nl, t_hour_nm, t_hour_nl;
   logic [3:0] a_sec_nm, a_sec_nl, a_min_nm, a_min_nl, a_hour_nm, a_hour_nl;
   logic [23:0] time_next;

   // While ringing every press only silences the alarm; otherwise mode > sel > inc
   assign any_btn = mode_btn | sel_btn | inc_btn;
   assign mode_p  = mode_btn & ~ring_q;
   assign sel_p   = sel_btn & ~mode_btn & ~ring_q;
   assign inc_p   = inc_btn & ~mode_btn & ~sel_btn & ~ring_q;

   // Prescaler is frozen in SET_TIME, so no tick may escape from there
   assign sec_tick = (presc_q == PrescMax) && (state_q != StSetTime);

   assign t_man = inc_p && (state_q == StSetTime);
   assign a_man = inc_p && (state_q == StSetAlarm);

   assign t_sec_inc  = sec_tick | (t_man && field_q == FldSec);
   assign t_min_inc  = (sec_tick & t_sec_c) | (t_man && field_q == FldMin);
   assign t_hour_inc = (sec_tick & t_sec_c & t_min_c) | (t_man && field_q == FldHour);
   assign a_sec_inc  = a_man && field_q == FldSec;
   assign a_min_inc  = a_man && field_q == FldMin;
   assign a_hour_inc = a_man && field_q == FldHour;

   assign time_next = {t_hour_inc ? {t_hour_nm, t_hour_nl} : {inhourMSB, inhourLSB},
                       t_min_inc  ? {t_min_nm, t_min_nl}   : {inminMSB, inminLSB},
                       t_sec_inc  ? {t_sec_nm, t_sec_nl}   : {insecMSB, insecLSB}};

   assign alarm_hit = sec_tick && (state_q == StRun) &&
                      (time_next == {alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB,
                                     alarmsecMSB, alarmsecLSB});

   bcd2_counter #(.Modulus(60)) u_t_sec (
      .clk(clk), .reset_n(reset_n), .inc(t_sec_inc), .msb(insecMSB), .lsb(insecLSB),
      .nxt_msb(t_sec_nm), .nxt_lsb(t_sec_nl), .carry(t_sec_c));
   bcd2_counter #(.Modulus(60)) u_t_min (
      .clk(clk), .reset_n(reset_n), .inc(t_min_inc), .msb(inminMSB), .lsb(inminLSB),
      .nxt_msb(t_min_nm), .nxt_lsb(t_min_nl), .carry(t_min_c));
   bcd2_counter #(.Modulus(24)) u_t_hour (
      .clk(clk), .reset_n(reset_n), .inc(t_hour_inc), .msb(inhourMSB), .lsb(inhourLSB),
      .nxt_msb(t_hour_nm), .nxt_lsb(t_hour_nl), .carry(t_hour_c));
   bcd2_counter #(.Modulus(60)) u_a_sec (
      .clk(clk), .reset_n(reset_n), .inc(a_sec_inc), .msb(alarmsecMSB), .lsb(alarmsecLSB),
      .nxt_msb(a_sec_nm), .nxt_lsb(a_sec_nl), .carry(a_sec_c));
   bcd2_counter #(.Modulus(60)) u_a_min (
      .clk(clk), .reset_n(reset_n), .inc(a_min_inc), .msb(alarmminMSB), .lsb(alarmminLSB),
      .nxt_msb(a_min_nm), .nxt_lsb(a_min_nl), .carry(a_min_c));
   bcd2_counter #(.Modulus(24)) u_a_hour (
      .clk(clk), .reset_n(reset_n), .inc(a_hour_inc), .msb(alarmhourMSB),
      .lsb(alarmhourLSB), .nxt_msb(a_hour_nm), .nxt_lsb(a_hour_nl), .carry(a_hour_c));

   // Alarm fields never carry and the hour wrap is not needed here
   logic unused_carry;
   assign unused_carry = ^{t_hour_c, a_sec_c, a_min_c, a_hour_c, a_sec_nm, a_sec_nl,
                           a_min_nm, a_min_nl, a_hour_nm, a_hour_nl};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StRun;
         field_q    <= FldHour;
         presc_q    <= '0;
         settime_q  <= 1'b0;
         ring_q     <= 1'b0;
`ifdef ALARM_AUTOOFF_EN
         ring_cnt_q <= '0;
`endif
      end else begin
         if (state_q == StSetTime) begin
            if (mode_p) presc_q <= '0;
         end else begin
            presc_q <= (presc_q == PrescMax) ? '0 : presc_q + 1'b1;
         end

         if (mode_p) begin
            field_q <= FldHour;
            unique case (state_q)
               StRun: begin
                  state_q   <= StSetTime;
                  settime_q <= 1'b1;
               end
               StSetTime: begin
                  state_q   <= StSetAlarm;
                  settime_q <= 1'b1;
               end
               default: begin
                  state_q   <= StRun;
                  settime_q <= 1'b0;
               end
            endcase
         end else if (sel_p && state_q != StRun) begin
            unique case (field_q)
               FldHour: field_q <= FldMin;
               FldMin:  field_q <= FldSec;
               default: field_q <= FldHour;
            endcase
         end

         if (ring_q) begin
            if (any_btn) begin
               ring_q     <= 1'b0;
`ifdef ALARM_AUTOOFF_EN
               ring_cnt_q <= '0;
            end else if (sec_tick) begin
               if (ring_cnt_q == 6'd59) begin
                  ring_q     <= 1'b0;
                  ring_cnt_q <= '0;
               end else begin
                  ring_cnt_q <= ring_cnt_q + 6'd1;
               end
`endif
            end
         end else if (alarm_hit) begin
            ring_q     <= 1'b1;
`ifdef ALARM_AUTOOFF_EN
            ring_cnt_q <= '0;
`endif
         end
      end
   end

   assign settime    = settime_q;
   assign alarm_ring = ring_q;

endmodule

// File: tb/tb_clock_core.sv
// Bench for clock_core: directed scenarios plus random presses against a seconds-of-day model.
module tb_clock_core;

   localparam int HZ = 4;
`ifdef ALARM_AUTOOFF_EN
   localparam bit AutoOff = 1'b1;
`else
   localparam bit AutoOff = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n, mode_btn, sel_btn, inc_btn;
   logic settime, alarm_ring;
   logic [3:0] insecMSB, insecLSB, inminMSB, inminLSB, inhourMSB, inhourLSB;
   logic [3:0] alarmsecMSB, alarmsecLSB, alarmminMSB, alarmminLSB, alarmhourMSB, alarmhourLSB;

   clock_core #(.CLK_HZ(HZ)) dut (
      .clk(clk), .reset_n(reset_n), .mode_btn(mode_btn), .sel_btn(sel_btn),
      .inc_btn(inc_btn), .settime(settime),
      .insecMSB(insecMSB), .insecLSB(insecLSB), .inminMSB(inminMSB), .inminLSB(inminLSB),
      .inhourMSB(inhourMSB), .inhourLSB(inhourLSB),
      .alarmsecMSB(alarmsecMSB), .alarmsecLSB(alarmsecLSB),
      .alarmminMSB(alarmminMSB), .alarmminLSB(alarmminLSB),
      .alarmhourMSB(alarmhourMSB), .alarmhourLSB(alarmhourLSB),
      .alarm_ring(alarm_ring));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: time and alarm as seconds of day; st 0=run 1=set time 2=set alarm; fld 0=h 1=m 2=s
   int m_t, m_a, m_st, m_fld, m_pc, m_rcnt;
   bit m_ring;

   function automatic logic [23:0] pack(int v);
      int h, mi, s;
      h = v / 3600; mi = (v / 60) % 60; s = v % 60;
      return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int bump(int v, int f);
      int h, mi, s;
      h = v / 3600; mi = (v / 60) % 60; s = v % 60;
      if (f == 0) h = (h + 1) % 24;
      else if (f == 1) mi = (mi + 1) % 60;
      else s = (s + 1) % 60;
      return h * 3600 + mi * 60 + s;
   endfunction

   function automatic logic [23:0] obs_time();
      return {inhourMSB, inhourLSB, inminMSB, inminLSB, insecMSB, insecLSB};
   endfunction

   function automatic logic [23:0] obs_alarm();
      return {alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB};
   endfunction

   task automatic model_reset();
      m_t = 0; m_a = 0; m_st = 0; m_fld = 0; m_pc = 0; m_rcnt = 0; m_ring = 1'b0;
   endtask

   task automatic model_step(bit md, bit sl, bit ic);
      bit m, s, i, tick, was_ringing;
      int t_new;
      m = md; s = sl & ~md; i = ic & ~md & ~sl;
      tick = (m_st != 1) && (m_pc == HZ - 1);
      was_ringing = m_ring;
      if (m_ring) begin
         if (md | sl | ic) begin
            m_ring = 1'b0; m_rcnt = 0;
         end else if (AutoOff && tick) begin
            if (m_rcnt == 59) begin
               m_ring = 1'b0; m_rcnt = 0;
            end else m_rcnt++;
         end
         m = 1'b0; s = 1'b0; i = 1'b0;
      end
      t_new = tick ? (m_t + 1) % 86400 : m_t;
      if (!was_ringing && tick && m_st == 0 && t_new == m_a) begin
         m_ring = 1'b1; m_rcnt = 0;
      end
      if (i && m_st == 1) t_new = bump(t_new, m_fld);
      if (i && m_st == 2) m_a = bump(m_a, m_fld);
      m_t = t_new;
      if (m_st == 1) begin
         if (m) m_pc = 0;
      end else m_pc = (m_pc == HZ - 1) ? 0 : m_pc + 1;
      if (m) m_fld = 0;
      else if (s && m_st != 0) m_fld = (m_fld + 1) % 3;
      if (m) m_st = (m_st + 1) % 3;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("settime", 64'(settime), 64'(m_st != 0));
      chk("time", 64'(obs_time()), 64'(pack(m_t)));
      chk("alarm", 64'(obs_alarm()), 64'(pack(m_a)));
      chk("ring", 64'(alarm_ring), 64'(m_ring));
      chk("sec_tick", 64'(dut.sec_tick), 64'((m_st != 1) && (m_pc == HZ - 1)));
   endtask

   task automatic step(bit md, bit sl, bit ic);
      mode_btn = md; sel_btn = sl; inc_btn = ic;
      @(posedge clk);
      model_step(md, sl, ic);
      #1;
      mode_btn = 1'b0; sel_btn = 1'b0; inc_btn = 1'b0;
      check_all();
   endtask

   // Drive a field set (time or alarm) to a target using the model's current value
   task automatic set_to(int target, bit alarm);
      int cur, n;
      for (int k = 0; k < 3 && m_fld != 0; k++) step(1'b0, 1'b1, 1'b0);
      cur = alarm ? m_a : m_t;
      n = (target / 3600 - cur / 3600 + 24) % 24;
      repeat (n) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      n = ((target / 60) % 60 - (cur / 60) % 60 + 60) % 60;
      repeat (n) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      n = (target % 60 - cur % 60 + 60) % 60;
      repeat (n) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int t0;
      logic [23:0] saved;
      reset_n = 1'b0; mode_btn = 1'b0; sel_btn = 1'b0; inc_btn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      check_all();
      reset_n = 1'b1;

      // 8 cycles at CLK_HZ=4 gives two seconds
      repeat (8) step(1'b0, 1'b0, 1'b0);
      chk("req028_seclsb", 64'(insecLSB), 64'd2);

      // Preload 23:59:59 and roll over in RUN
      step(1'b1, 1'b0, 1'b0);
      set_to(86399, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8 && obs_time() == 24'h235959; k++) step(1'b0, 1'b0, 1'b0);
      chk("req029_wrap", 64'(obs_time()), 64'h0);
      // Alarm 00:00:00 matches the wrap, so it rings; a press silences it
      chk("req029_ring", 64'(alarm_ring), 64'd1);
      step(1'b0, 1'b0, 1'b1);
      chk("ring_cleared", 64'(alarm_ring), 64'd0);

      // Minutes of the alarm wrap without carrying into the hour
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      t0 = m_t;
      step(1'b0, 1'b1, 1'b0);
      repeat (61) step(1'b0, 1'b0, 1'b1);
      chk("req030_alarm", 64'(obs_alarm()), 64'h000100);
      chk("req030_time_adv", 64'(obs_time() == pack(t0)), 64'd0);

      // Alarm at 00:00:03, then time from 00:00:00
      set_to(3, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      set_to(0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 40 && alarm_ring !== 1'b1; k++) step(1'b0, 1'b0, 1'b0);
      chk("req031_ring", 64'(alarm_ring), 64'd1);
      chk("req031_time", 64'(obs_time()), 64'h000003);
      step(1'b0, 1'b0, 1'b0);
      saved = pack(m_t);
      step(1'b0, 1'b0, 1'b1);
      chk("req031_clear", 64'(alarm_ring), 64'd0);
      chk("req031_time_kept", 64'(obs_time()), 64'(saved));

      // mode wins over inc; then async reset mid SET_ALARM
      step(1'b1, 1'b0, 1'b0);
      saved = pack(m_t);
      step(1'b1, 1'b0, 1'b1);
      chk("req032_settime", 64'(settime), 64'd1);
      chk("req032_time", 64'(obs_time()), 64'(saved));
      step(1'b0, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("req032_async", {14'h0, settime, alarm_ring, obs_time(), obs_alarm()}, 64'h0);
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;

      // Ring at 00:00:30, then 60 ticks with no presses
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      set_to(30, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 200 && alarm_ring !== 1'b1; k++) step(1'b0, 1'b0, 1'b0);
      chk("req033_ring", 64'(alarm_ring), 64'd1);
      repeat (60 * HZ) step(1'b0, 1'b0, 1'b0);
      chk("req033_autooff", 64'(alarm_ring), 64'(!AutoOff));
      step(1'b0, 1'b1, 1'b0);

      // Random presses, including simultaneous ones
      for (int k = 0; k < 800; k++) begin
         int r;
         r = int'($urandom_range(0, 99));
         step(r < 3 || r == 40, (r >= 3 && r < 9) || r == 40 || r == 41, r >= 9 && r < 24 || r == 41);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
